// File: rtl/pe_pkg.sv
// Shared PE definitions: word width, PE array dimensions, mode codes and loader states.
package pe_pkg;
    localparam int PE_WW    = 16;
    localparam int PE_N_IN  = 16;
    localparam int PE_N_OUT = 4;

    localparam logic [1:0] MODE_WUPD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;

    typedef enum logic [1:0] {
        LD_LOAD = 2'd0,
        LD_FIRE = 2'd1,
        LD_WAIT = 2'd2
    } loader_state_e;
endpackage

// File: rtl/pe_loader_16x4.sv
// Streams one frame of D then W words into the pe_16x4 operand registers, then pulses ce and waits out the PE latency.
// Optional feature: define PE_LOADER_WSKIP_EN to add w_skip (D-only frames that keep the W registers).
import pe_pkg::*;

module pe_loader_16x4 #(
    parameter int N_D    = PE_N_IN,
    parameter int N_W    = 64,
    parameter int PE_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PE_WW-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0]            cmd_mode,
`ifdef PE_LOADER_WSKIP_EN
    input  logic                  w_skip,
`endif
    output logic [PE_WW*N_D-1:0]  d_bus,
    output logic [PE_WW*N_W-1:0]  w_bus,
    output logic                  pe_ce,
    output logic [1:0]            pe_mode,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);
    localparam int N_TOT = N_D + N_W;
    localparam int CW    = $clog2(N_TOT + 1);
    localparam int LW    = $clog2(PE_LAT + 1);

    localparam logic [1:0] S_LOAD = LD_LOAD;
    localparam logic [1:0] S_FIRE = LD_FIRE;
    localparam logic [1:0] S_WAIT = LD_WAIT;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_count;
    logic [LW-1:0]        r_wait;
    logic [PE_WW*N_D-1:0] r_d;
    logic [PE_WW*N_W-1:0] r_w;
    logic [1:0]           r_mode;
    logic                 w_accept;
    logic                 w_last;
    logic [CW-1:0]        w_last_idx;

`ifdef PE_LOADER_WSKIP_EN
    logic r_skip;
    logic w_skip_now;
    // The skip flag travels with word 0, so that word must see the live input.
    assign w_skip_now = (r_count == '0) ? w_skip : r_skip;
    assign w_last_idx = w_skip_now ? CW'(N_D - 1) : CW'(N_TOT - 1);
`else
    assign w_last_idx = CW'(N_TOT - 1);
`endif

    assign w_accept  = s_valid && s_ready;
    assign w_last    = (r_count == w_last_idx);

    // Status outputs are forced low while rst is held, not just after the first edge.
    assign s_ready   = !rst && (r_state == S_LOAD);
    assign pe_ce     = !rst && (r_state == S_FIRE);
    assign done      = !rst && (r_state == S_WAIT) && (r_wait == LW'(PE_LAT - 1));
    assign busy      = !rst && ((r_state != S_LOAD) || (r_count != '0));
    assign d_bus     = r_d;
    assign w_bus     = r_w;
    assign pe_mode   = r_mode;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_wait  <= '0;
            r_d     <= '0;
            r_w     <= '0;
            r_mode  <= MODE_WUPD;
`ifdef PE_LOADER_WSKIP_EN
            r_skip  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        for (int k = 0; k < N_D; k++) begin
                            if (r_count == CW'(k)) r_d[PE_WW*k +: PE_WW] <= s_data;
                        end
                        for (int k = 0; k < N_W; k++) begin
                            if (r_count == CW'(N_D + k)) r_w[PE_WW*k +: PE_WW] <= s_data;
                        end
                        if (r_count == '0) begin
                            r_mode <= cmd_mode;
`ifdef PE_LOADER_WSKIP_EN
                            r_skip <= w_skip;
`endif
                        end
                        if (w_last) begin
                            r_count <= '0;
                            r_state <= S_FIRE;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                S_FIRE: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == LW'(PE_LAT - 1)) r_state <= S_LOAD;
                    else                           r_wait  <= r_wait + LW'(1);
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_loader_16x4.sv
// Bench for pe_loader_16x4: directed frame table plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_pe_loader_16x4;
    import pe_pkg::*;

    localparam int N_D    = 16;
    localparam int N_W    = 64;
    localparam int PE_LAT = 2;
    localparam int N_TOT  = N_D + N_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [15:0]          s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [1:0]           cmd_mode;
    logic [16*N_D-1:0]    d_bus;
    logic [16*N_W-1:0]    w_bus;
    logic                 pe_ce;
    logic [1:0]           pe_mode;
    logic                 busy;
    logic                 done;
    logic [1:0]           dbg_state;
`ifdef PE_LOADER_WSKIP_EN
    logic                 w_skip;
`endif

    always #5 clk = ~clk;

    pe_loader_16x4 #(.N_D(N_D), .N_W(N_W), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cmd_mode(cmd_mode),
`ifdef PE_LOADER_WSKIP_EN
        .w_skip(w_skip),
`endif
        .d_bus(d_bus), .w_bus(w_bus), .pe_ce(pe_ce), .pe_mode(pe_mode),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int frames_done = 0;

    // Frame-level model: words of the in-flight frame queue up and land in D/W when the frame fires.
    logic [15:0] exp_q[$];
    logic [15:0] exp_d[N_D];
    logic [15:0] exp_w[N_W];
    logic [1:0]  exp_mode;

    always @(posedge clk) if (done) done_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int k = 0; k < N_D; k++) exp_d[k] = '0;
        for (int k = 0; k < N_W; k++) exp_w[k] = '0;
        exp_mode = MODE_WUPD;
    endtask

    task automatic chk_regs(input string tag);
        int nd = 0;
        int nw = 0;
        int fd = 0;
        int fw = 0;
        for (int k = N_D - 1; k >= 0; k--)
            if (d_bus[16*k +: 16] !== exp_d[k]) begin nd++; fd = k; end
        for (int k = N_W - 1; k >= 0; k--)
            if (w_bus[16*k +: 16] !== exp_w[k]) begin nw++; fw = k; end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL %s d_bus: %0d words differ, D%0d got %0h expected %0h",
                     tag, nd, fd, d_bus[16*fd +: 16], exp_d[fd]);
        end
        total++;
        if (nw != 0) begin
            bad++;
            $display("FAIL %s w_bus: %0d words differ, W%0d got %0h expected %0h",
                     tag, nw, fw, w_bus[16*fw +: 16], exp_w[fw]);
        end
        chk({tag, " pe_mode"}, pe_mode, exp_mode);
    endtask

    // Holds rst for ncyc edges, then releases it just after an edge.
    task automatic apply_reset(input int ncyc);
        rst = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("rst_outputs {s_ready,pe_ce,done,busy}", {s_ready, pe_ce, done, busy}, 4'b0000);
        end
        model_clear();
        chk_regs("rst");
        chk("rst_state", dbg_state, LD_LOAD);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("first_cycle_s_ready", s_ready, 1'b1);
    endtask

    task automatic drive_junk();
        s_valid  = 1'b1;
        s_data   = 16'($urandom);
        cmd_mode = 2'($urandom);
`ifdef PE_LOADER_WSKIP_EN
        w_skip   = 1'($urandom);
`endif
    endtask

    // Sends nwords (with an optional stall before word stall_at); when finish is set it also
    // checks the FIRE/WAIT sequence and reports the FIRE cycle offset from the frame start.
    task automatic send_frame(input logic [1:0] mode, input int stall_at, input int stall_len,
                              input logic [15:0] base, input int step, input bit rnd,
                              input bit flip, input int nwords, input bit skip,
                              input bit finish, output int ce_off);
        int n = 0;
        int stalled = 0;
        int cyc = 0;
        bit found = 1'b0;
        logic [15:0] w;
        ce_off = -1;
        while (n < nwords && cyc < 400) begin
            @(negedge clk);
            chk("load {s_ready,pe_ce,done,busy}", {s_ready, pe_ce, done, busy},
                {1'b1, 1'b0, 1'b0, (n != 0)});
            if (n == stall_at && stalled < stall_len) begin
                s_valid  = 1'b0;
                s_data   = 16'($urandom);
                cmd_mode = 2'($urandom);
                stalled++;
            end else begin
                w = rnd ? 16'($urandom) : 16'(base + n * step);
                s_valid  = 1'b1;
                s_data   = w;
                cmd_mode = (n == 0) ? mode : (flip ? ~mode : 2'($urandom));
`ifdef PE_LOADER_WSKIP_EN
                w_skip   = (n == 0) ? skip : 1'($urandom);
`endif
                exp_q.push_back(w);
                n++;
            end
            cyc++;
            @(posedge clk);
        end
        if (!finish) begin
            #1 s_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 4 && !found; i++) begin
            #1 drive_junk();
            @(negedge clk);
            if (pe_ce) begin
                found = 1'b1;
                ce_off = cyc + i;
            end else begin
                @(posedge clk);
            end
        end
        chk("fire_seen", found, 1'b1);
        if (!found) begin
            s_valid = 1'b0;
            return;
        end
        chk("fire {s_ready,busy,done}", {s_ready, busy, done}, 3'b010);
        for (int k = 0; exp_q.size() > 0; k++) begin
            w = exp_q.pop_front();
            if (k < N_D) exp_d[k] = w;
            else         exp_w[k - N_D] = w;
        end
        exp_mode = mode;
        for (int i = 1; i <= PE_LAT; i++) begin
            @(posedge clk);
            #1 drive_junk();
            @(negedge clk);
            chk("wait {pe_ce,s_ready,busy}", {pe_ce, s_ready, busy}, 3'b001);
            chk("wait_done", done, (i == PE_LAT));
            chk_regs("wait");
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        frames_done++;
        chk("after_done {s_ready,busy,pe_ce,done}", {s_ready, busy, pe_ce, done}, 4'b1000);
        chk_regs("frame");
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          stall_at;
        int          stall_len;
        logic [15:0] base;
        int          step;
        bit          rnd;
        bit          flip;
        int          exp_ce;
        logic [1:0]  exp_mode;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ce_off;
        int d_before;
        int len;
        logic [1:0] m;
        logic [15:0] wd0;
        logic [15:0] wd63;

        vecs[0] = '{2'b01, -1,  0, 16'd1,     1, 1'b0, 1'b0, 80, 2'b01};
        vecs[1] = '{2'b01, 41,  5, 16'd1,     1, 1'b0, 1'b0, 85, 2'b01};
        vecs[2] = '{2'b00, -1,  0, 16'h0100,  3, 1'b0, 1'b1, 80, 2'b00};
        vecs[3] = '{2'b10,  0,  3, 16'h0000,  0, 1'b1, 1'b0, 83, 2'b10};
        vecs[4] = '{2'b11, 79,  7, 16'h0000,  0, 1'b1, 1'b0, 87, 2'b11};
        vecs[5] = '{2'b01, 16,  2, 16'hF000, 17, 1'b0, 1'b0, 82, 2'b01};

        s_data = '0;
        s_valid = 1'b0;
        cmd_mode = 2'b00;
`ifdef PE_LOADER_WSKIP_EN
        w_skip = 1'b0;
`endif
        apply_reset(3);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].mode, vecs[i].stall_at, vecs[i].stall_len, vecs[i].base,
                       vecs[i].step, vecs[i].rnd, vecs[i].flip, N_TOT, 1'b0, 1'b1, ce_off);
            chk($sformatf("vec%0d ce_cycle", i), ce_off, vecs[i].exp_ce);
            chk($sformatf("vec%0d pe_mode", i), pe_mode, vecs[i].exp_mode);
            if (i < 2) begin
                chk("D0", d_bus[15:0], 16'd1);
                chk("D15", d_bus[16*15 +: 16], 16'd16);
                chk("W0", w_bus[15:0], 16'd17);
                chk("W63", w_bus[16*63 +: 16], 16'd80);
            end
        end

        for (int i = 0; i < 4; i++) begin
            m = 2'($urandom);
            len = $urandom_range(0, 6);
            send_frame(m, $urandom_range(0, N_TOT - 1), len, 16'h0, 0, 1'b1, 1'b0,
                       N_TOT, 1'b0, 1'b1, ce_off);
            chk("rand ce_cycle", ce_off, N_TOT + len);
        end

        // Reset in the middle of loading, then a full constant frame.
        d_before = done_seen;
        send_frame(2'b01, -1, 0, 16'h1234, 1, 1'b0, 1'b0, 50, 1'b0, 1'b0, ce_off);
        apply_reset(3);
        chk("midframe_rst no done", done_seen, d_before);
        send_frame(2'b01, -1, 0, 16'hA5A5, 0, 1'b0, 1'b0, N_TOT, 1'b0, 1'b1, ce_off);
        chk("a5 ce_cycle", ce_off, N_TOT);
        chk("a5 one done", done_seen, d_before + 1);

        // Reset during WAIT must swallow that frame's done.
        d_before = done_seen;
        send_frame(2'b10, -1, 0, 16'h0042, 1, 1'b0, 1'b0, N_TOT, 1'b0, 1'b0, ce_off);
        @(negedge clk);
        chk("midwait fire", pe_ce, 1'b1);
        @(posedge clk);
        #1;
        apply_reset(2);
        chk("midwait_rst no done", done_seen, d_before);

`ifdef PE_LOADER_WSKIP_EN
        send_frame(2'b01, -1, 0, 16'h0300, 5, 1'b0, 1'b0, N_TOT, 1'b0, 1'b1, ce_off);
        wd0 = w_bus[15:0];
        wd63 = w_bus[16*63 +: 16];
        send_frame(2'b11, -1, 0, 16'h0007, 0, 1'b0, 1'b0, N_D, 1'b1, 1'b1, ce_off);
        chk("skip ce_cycle", ce_off, N_D);
        chk("skip W0 kept", w_bus[15:0], wd0);
        chk("skip W63 kept", w_bus[16*63 +: 16], wd63);
        chk("skip D15", d_bus[16*15 +: 16], 16'h0007);
`else
        wd0 = w_bus[15:0];
        wd63 = w_bus[16*63 +: 16];
        chk("post_rst W0", wd0, 16'h0000);
        chk("post_rst W63", wd63, 16'h0000);
`endif

        chk("done_count", done_seen, frames_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
